// File: rtl/pwm_measure.sv
// pwm_measure: measures high time and period of an asynchronous PWM input in
// clk cycles. It reports one measurement per complete rising-to-rising period
// and flags loss of signal when no edge is seen for TIMEOUT_CYCLES cycles.
module pwm_measure #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2_500_000,
  parameter int unsigned SYNC_STAGES    = 32'd2
) (
  input  logic        clk,
  input  logic        rst_a_n,
  input  logic        pwm_in,
  output logic [31:0] high_cnt,
  output logic [31:0] period_cnt,
  output logic        meas_valid,
  output logic        signal_lost,
  output logic        stuck_level
);

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  // Idle count at which the next edgeless cycle completes the timeout window.
  localparam logic [31:0] IDLE_LAST = TIMEOUT_CYCLES - 32'd1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES:0]   prime_r;
  logic                   s_in_s;
  logic                   s_d_r;
  logic                   primed_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   edge_s;
  logic                   timeout_s;

  state_t      state_r, state_nxt;
  logic [31:0] hacc_r, hacc_nxt;
  logic [31:0] pacc_r, pacc_nxt;
  logic [31:0] idle_r, idle_nxt;
  logic [31:0] high_cnt_r, high_nxt;
  logic [31:0] period_cnt_r, period_nxt;
  logic        meas_valid_r, meas_nxt;
  logic        signal_lost_r, lost_nxt;
  logic        stuck_level_r, stuck_nxt;

  assign s_in_s    = sync_r[SYNC_STAGES-1];
  assign primed_s  = prime_r[SYNC_STAGES];
  assign rise_s    = s_in_s & ~s_d_r;
  assign fall_s    = ~s_in_s & s_d_r;
  assign edge_s    = rise_s | fall_s;
  // An edge in the same cycle always wins over the timeout.
  assign timeout_s = (state_r != ARM) && !edge_s && (idle_r == IDLE_LAST);

  // Synchronize pwm_in and keep a one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync_r <= '0;
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
      s_d_r  <= s_in_s;
    end
  end

  // Mark the synchronizer as primed once it holds real samples; before that
  // its reset zeros must not be mistaken for a low input level.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      prime_r <= '0;
    end else begin
      prime_r <= {prime_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_r <= ARM;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, accumulator, timer and output update logic.
  always_comb begin
    state_nxt  = state_r;
    hacc_nxt   = hacc_r;
    pacc_nxt   = pacc_r;
    high_nxt   = high_cnt_r;
    period_nxt = period_cnt_r;
    meas_nxt   = 1'b0;
    lost_nxt   = signal_lost_r;
    stuck_nxt  = stuck_level_r;

    if ((state_r == ARM) || edge_s) begin
      idle_nxt = 32'd0;
    end else begin
      idle_nxt = idle_r + 32'd1;
    end

    if (timeout_s) begin
      state_nxt = ARM;
      lost_nxt  = 1'b1;
      stuck_nxt = s_in_s;
      idle_nxt  = 32'd0;
      hacc_nxt  = 32'd0;
      pacc_nxt  = 32'd0;
    end else begin
      case (state_r)
        ARM: begin
          hacc_nxt = 32'd0;
          pacc_nxt = 32'd0;
          if (primed_s && !s_in_s) begin
            state_nxt = WAIT_RISE;
          end else begin
            state_nxt = ARM;
          end
        end
        WAIT_RISE: begin
          if (rise_s) begin
            state_nxt = HIGH;
            hacc_nxt  = 32'd1;
            pacc_nxt  = 32'd1;
          end else begin
            state_nxt = WAIT_RISE;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_nxt = LOW;
            pacc_nxt  = pacc_r + 32'd1;
          end else begin
            hacc_nxt  = hacc_r + 32'd1;
            pacc_nxt  = pacc_r + 32'd1;
          end
        end
        LOW: begin
          if (rise_s) begin
            // Period complete: publish it and start the next one.
            state_nxt  = HIGH;
            high_nxt   = hacc_r;
            period_nxt = pacc_r;
            meas_nxt   = 1'b1;
            lost_nxt   = 1'b0;
            hacc_nxt   = 32'd1;
            pacc_nxt   = 32'd1;
          end else begin
            pacc_nxt   = pacc_r + 32'd1;
          end
        end
        default: begin
          state_nxt = ARM;
          hacc_nxt  = 32'd0;
          pacc_nxt  = 32'd0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      hacc_r        <= 32'd0;
      pacc_r        <= 32'd0;
      idle_r        <= 32'd0;
      high_cnt_r    <= 32'd0;
      period_cnt_r  <= 32'd0;
      meas_valid_r  <= 1'b0;
      signal_lost_r <= 1'b0;
      stuck_level_r <= 1'b0;
    end else begin
      hacc_r        <= hacc_nxt;
      pacc_r        <= pacc_nxt;
      idle_r        <= idle_nxt;
      high_cnt_r    <= high_nxt;
      period_cnt_r  <= period_nxt;
      meas_valid_r  <= meas_nxt;
      signal_lost_r <= lost_nxt;
      stuck_level_r <= stuck_nxt;
    end
  end

  assign high_cnt    = high_cnt_r;
  assign period_cnt  = period_cnt_r;
  assign meas_valid  = meas_valid_r;
  assign signal_lost = signal_lost_r;
  assign stuck_level = stuck_level_r;

endmodule

// File: tb/tb_pwm_measure.sv
// Self-checking bench for pwm_measure: reset behaviour, table-driven periodic
// patterns, hand-written corner sequences and randomized periods compared
// against an edge-list reference model.
module tb_pwm_measure;

  localparam int unsigned TOUT = 32'd5000;
  localparam int unsigned SYNC = 32'd2;
  localparam int unsigned LAT  = SYNC + 32'd1;

  logic        clk;
  logic        rst_a_n;
  logic        pwm_in;
  logic [31:0] high_cnt;
  logic [31:0] period_cnt;
  logic        meas_valid;
  logic        signal_lost;
  logic        stuck_level;

  typedef struct {
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] per;
  } ev_t;

  typedef struct {
    int unsigned h;
    int unsigned l;
    int unsigned n;
    int unsigned exp_pulses;
    logic [31:0] exp_hi;
    logic [31:0] exp_per;
  } vec_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  ev_t         mon_ev;
  int unsigned cyc;
  int unsigned checks;
  int unsigned failures;

  pwm_measure #(
    .TIMEOUT_CYCLES(TOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk        (clk),
    .rst_a_n    (rst_a_n),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .signal_lost(signal_lost),
    .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index used to timestamp stimulus and results.
  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Log every measurement pulse away from the active edge.
  always @(negedge clk) begin
    if (rst_a_n && meas_valid) begin
      mon_ev.cyc = cyc;
      mon_ev.hi  = high_cnt;
      mon_ev.per = period_cnt;
      obs_q.push_back(mon_ev);
    end
  end

  // Hard stop if something hangs.
  initial begin
    #900_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 32'd1;
    if (act !== exp) begin
      failures = failures + 32'd1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold pwm_in at lvl for n cycles; entered and left just after a rising edge.
  task automatic drive(input logic lvl, input int unsigned n);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    pwm_in  = lvl;
    rst_a_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_a_n = 1'b1;
  endtask

  // Compare logged pulses against the expected list.
  task automatic compare_events(input string tag);
    int unsigned n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, "_cycle"},  obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_high"},   obs_q[i].hi,  exp_q[i].hi);
      chk({tag, "_period"}, obs_q[i].per, exp_q[i].per);
    end
  endtask

  task automatic add_exp(input int unsigned c, input logic [31:0] h, input logic [31:0] p);
    ev_t e;
    e.cyc = c;
    e.hi  = h;
    e.per = p;
    exp_q.push_back(e);
  endtask

  initial begin
    vec_t        vecs[5];
    int unsigned rises[$];
    int unsigned r, ra, rb, lost_cyc, prev_r, prev_h, h, l;

    checks   = 32'd0;
    failures = 32'd0;
    rst_a_n  = 1'b0;
    pwm_in   = 1'b0;

    // Reset held for 5 cycles with a toggling input: everything stays zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs", {high_cnt[29:0], period_cnt[29:0], meas_valid, signal_lost},
          32'd0);
      chk("reset_stuck", 32'(stuck_level) | 32'(high_cnt[31:30]) | 32'(period_cnt[31:30]), 32'd0);
      pwm_in = ~pwm_in;
    end
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;

    // Periodic patterns: H high / L low repeated N times.
    vecs[0] = '{h: 100, l: 900, n: 5, exp_pulses: 4, exp_hi: 32'd100, exp_per: 32'd1000};
    vecs[1] = '{h: 1,   l: 49,  n: 3, exp_pulses: 2, exp_hi: 32'd1,   exp_per: 32'd50};
    vecs[2] = '{h: 7,   l: 3,   n: 4, exp_pulses: 3, exp_hi: 32'd7,   exp_per: 32'd10};
    vecs[3] = '{h: 1,   l: 1,   n: 4, exp_pulses: 3, exp_hi: 32'd1,   exp_per: 32'd2};
    vecs[4] = '{h: 3,   l: 1,   n: 3, exp_pulses: 2, exp_hi: 32'd3,   exp_per: 32'd4};
    for (int v = 0; v < 5; v++) begin
      do_reset(1'b0);
      obs_q.delete();
      exp_q.delete();
      rises.delete();
      drive(1'b0, 20);
      for (int unsigned p = 0; p < vecs[v].n; p++) begin
        rises.push_back(cyc);
        drive(1'b1, vecs[v].h);
        drive(1'b0, vecs[v].l);
      end
      drive(1'b0, 10);
      for (int unsigned k = 0; k < vecs[v].exp_pulses; k++) begin
        add_exp(rises[k + 1] + LAT, vecs[v].exp_hi, vecs[v].exp_per);
      end
      compare_events($sformatf("vec%0d", v));
    end

    // Input high at reset release: only the rise after a full low counts.
    do_reset(1'b1);
    obs_q.delete();
    exp_q.delete();
    drive(1'b1, 50);
    drive(1'b0, 50);
    drive(1'b1, 100);
    drive(1'b0, 200);
    r = cyc;
    drive(1'b1, 20);
    add_exp(r + LAT, 32'd100, 32'd300);
    compare_events("high_at_release");

    // Loss of signal with the input stuck high, then recovery.
    do_reset(1'b0);
    obs_q.delete();
    exp_q.delete();
    drive(1'b0, 20);
    drive(1'b1, 100);
    drive(1'b0, 900);
    r = cyc;
    pwm_in = 1'b1;
    lost_cyc = 32'd0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      #1;
      if (signal_lost) begin
        lost_cyc = cyc;
        break;
      end
    end
    chk("lost_set",    32'(signal_lost), 32'd1);
    chk("lost_cycle",  lost_cyc, r + LAT + TOUT);
    chk("stuck_level", 32'(stuck_level), 32'd1);
    chk("lost_high",   high_cnt, 32'd100);
    chk("lost_period", period_cnt, 32'd1000);
    add_exp(r + LAT, 32'd100, 32'd1000);
    compare_events("pre_loss");
    drive(1'b1, 30);
    chk("lost_holds", 32'(signal_lost), 32'd1);
    drive(1'b0, 900);
    ra = cyc;
    drive(1'b1, 100);
    drive(1'b0, 900);
    rb = cyc;
    drive(1'b1, 2);
    chk("lost_before_meas", 32'(signal_lost), 32'd1);
    chk("no_meas_before",   32'(meas_valid), 32'd0);
    drive(1'b1, 1);
    chk("recover_meas",   32'(meas_valid), 32'd1);
    chk("recover_lost",   32'(signal_lost), 32'd0);
    chk("recover_stuck",  32'(stuck_level), 32'd1);
    chk("recover_high",   high_cnt, 32'd100);
    chk("recover_period", period_cnt, 32'd1000);
    chk("recover_span",   rb - ra, 32'd1000);

    // Reset pulse during the high phase of the third period.
    do_reset(1'b0);
    obs_q.delete();
    exp_q.delete();
    drive(1'b0, 20);
    drive(1'b1, 100);
    drive(1'b0, 900);
    drive(1'b1, 100);
    drive(1'b0, 900);
    drive(1'b1, 50);
    chk("pre_reset_high", high_cnt, 32'd100);
    chk("pre_reset_events", obs_q.size(), 32'd2);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("midreset_high",   high_cnt, 32'd0);
    chk("midreset_period", period_cnt, 32'd0);
    chk("midreset_flags",  {29'd0, meas_valid, signal_lost, stuck_level}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    obs_q.delete();
    drive(1'b1, 50);
    drive(1'b0, 900);
    drive(1'b1, 100);
    drive(1'b0, 900);
    rb = cyc;
    drive(1'b1, 100);
    drive(1'b0, 20);
    add_exp(rb + LAT, 32'd100, 32'd1000);
    compare_events("after_midreset");

    // Random periods: the model reports, for each rise after the first, the
    // high time that followed the previous rise and the rise-to-rise gap.
    for (int round = 0; round < 3; round++) begin
      do_reset(1'b0);
      obs_q.delete();
      exp_q.delete();
      drive(1'b0, 12);
      prev_r = 32'd0;
      prev_h = 32'd0;
      for (int p = 0; p < 25; p++) begin
        h = $urandom_range(40, 1);
        l = $urandom_range(40, 1);
        r = cyc;
        if (p > 0) begin
          add_exp(r + LAT, prev_h, r - prev_r);
        end
        prev_r = r;
        prev_h = h;
        drive(1'b1, h);
        drive(1'b0, l);
      end
      drive(1'b0, 10);
      compare_events($sformatf("rand%0d", round));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
